count_capture: RTL
==================

COUNT_CAPTURE -- requirements
Module: count_capture

Interface
REQ-001 Parameter Size, default 5: width of the sampled count, equal to the upstream counter's Size.
REQ-002 Parameter Depth, default 4: FIFO entries, power of two, 2..16.
REQ-003 Parameter EpochWidth, default 3: width of the wrap-epoch tag.
REQ-004 clock  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 count  input  Size  live count from the upstream counter.
REQ-007 capture  input  1  request to snapshot count on this edge.
REQ-008 clear_overflow  input  1  clears the sticky overflow flag.
REQ-009 out_ready  input  1  consumer accepts the head entry.
REQ-010 out_valid  output  1  head entry present.
REQ-011 out_count  output  Size  count field of the head entry.
REQ-012 out_epoch  output  EpochWidth  epoch field of the head entry.
REQ-013 full  output  1  FIFO holds Depth entries.
REQ-014 empty  output  1  FIFO holds 0 entries.
REQ-015 overflow  output  1  sticky flag: a capture was dropped.
REQ-016 epoch  output  EpochWidth  live wrap-epoch counter.

Function
REQ-017 The block SHALL register count each cycle into prev_count and SHALL set prev_valid on the first posedge after reset.
REQ-018 A wrap SHALL be detected on a posedge where prev_valid=1 and count < prev_count (unsigned).
REQ-019 epoch SHALL increment by 1 on each detected wrap, modulo 2^EpochWidth.
REQ-020 On a posedge with capture=1 and full=0, the block SHALL push {epoch_next, count}; epoch_next is the epoch value after this edge's wrap increment.
REQ-021 Push SHALL be accepted only if full=0 before the edge; capture=1 with full=1 SHALL drop the entry and set overflow, even when a pop occurs on the same edge.
REQ-022 Pop SHALL occur on a posedge with out_valid=1 and out_ready=1; out_ready while empty SHALL be ignored.
REQ-023 Output SHALL be first-word-fall-through: an entry pushed at edge N SHALL appear on out_valid/out_count/out_epoch after edge N when the FIFO was empty before it.
REQ-024 A simultaneous push and pop with 0<occupancy<Depth SHALL leave occupancy unchanged and keep entry order.
REQ-025 out_count/out_epoch SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 full SHALL equal (occupancy==Depth) and empty SHALL equal (occupancy==0), both registered-consistent with the FIFO state.
REQ-027 clear_overflow=1 SHALL clear overflow; a drop on the same edge SHALL win and leave overflow=1.
REQ-028 FIFO read and write pointers SHALL wrap modulo Depth, with one extra bit to distinguish full from empty.

Reset
REQ-029 Asserting reset SHALL clear immediately: out_valid=0, empty=1, full=0, overflow=0, epoch=0, prev_valid=0, prev_count=0, pointers=0.
REQ-030 Reset asserted mid-operation SHALL discard all FIFO contents; entries SHALL NOT reappear after reset deasserts.
REQ-031 The first posedge after reset deassertion SHALL NOT detect a wrap.

Structure
REQ-032 Default widths and depth constants SHALL live in the shared counter definitions header used by the counter benches.
REQ-033 Storage and pointers SHALL be one sub-module, capture_fifo (Width, Depth parameters; push/pop/full/empty); wrap detection and the epoch counter SHALL stay in count_capture.

Verification
REQ-034 Reset, then capture at count=7 with out_ready=0 -> next cycle out_valid=1, out_count=7, out_epoch=0, empty=0.
REQ-035 Count running 30,31,0 with Size=5 -> epoch 0->1 on the edge where count=0; capture on that edge -> out_epoch=1, out_count=0.
REQ-036 Five captures (count 1..5) with out_ready=0, Depth=4 -> full=1 after the 4th, 5th dropped, overflow=1; drain yields 1,2,3,4 in order, then empty=1.
REQ-037 Full FIFO, capture=1 and out_ready=1 on the same edge -> one pop, no push, overflow=1, occupancy 3.
REQ-038 overflow=1, clear_overflow=1 with no drop -> overflow=0; clear_overflow with a simultaneous drop -> overflow stays 1.
REQ-039 Reset pulsed with 3 entries queued, between posedges -> out_valid=0 and empty=1 immediately, epoch=0; the first posedge after release shows no wrap.

Source files
------------

// File: rtl/count_capture_pkg.sv
// count_capture_pkg: shared widths and FIFO depth for the counter family and its benches.
package count_capture_pkg;
  localparam int SIZE    = 5;
  localparam int DEPTH   = 4;
  localparam int EPOCH_W = 3;
endpackage

// File: rtl/count_capture_if.sv
// count_capture_if: live count in, captured {epoch,count} stream and status out.
interface count_capture_if #(
  parameter int Size       = 5,
  parameter int EpochWidth = 3
);
  logic [Size-1:0]       count;
  logic                  capture;
  logic                  clear_overflow;
  logic                  out_ready;
  logic                  out_valid;
  logic [Size-1:0]       out_count;
  logic [EpochWidth-1:0] out_epoch;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic [EpochWidth-1:0] epoch;
  modport master (
    output count, capture, clear_overflow, out_ready,
    input  out_valid, out_count, out_epoch, full, empty, overflow, epoch
  );
  modport slave (
    input  count, capture, clear_overflow, out_ready,
    output out_valid, out_count, out_epoch, full, empty, overflow, epoch
  );
endinterface

// File: rtl/capture_fifo.sv
// capture_fifo: first-word-fall-through FIFO; pointers carry one extra bit to tell full from empty.
module capture_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(Depth);
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             wr_en, rd_en;
  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = wr_ptr_q == rd_ptr_q;
    wr_en    = push && !full;
    rd_en    = pop && !empty;
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_en);
    rdata    = mem_q[rd_ptr_q[AW-1:0]];
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  // storage needs no reset: pointers alone define which entries are live
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/count_capture.sv
// count_capture: snapshots an upstream counter into a FIFO, tagging each sample with a wrap epoch.
module count_capture
  import count_capture_pkg::*;
#(
  parameter int Size       = SIZE,
  parameter int Depth      = DEPTH,
  parameter int EpochWidth = EPOCH_W
) (
  input logic           clock,
  input logic           reset,
  count_capture_if.slave bus
);
  logic [Size-1:0]            prev_count_q, prev_count_d;
  logic                       prev_valid_q, prev_valid_d;
  logic [EpochWidth-1:0]      epoch_q, epoch_d;
  logic                       overflow_q, overflow_d;
  logic                       wrap, fifo_full, fifo_empty;
  logic [EpochWidth+Size-1:0] head;
  always_comb begin
    wrap         = prev_valid_q && (bus.count < prev_count_q);
    epoch_d      = epoch_q + EpochWidth'(wrap);
    prev_count_d = bus.count;
    prev_valid_d = 1'b1;
    // a drop on this edge outranks a clear request
    overflow_d   = (bus.capture && fifo_full) ? 1'b1 : bus.clear_overflow ? 1'b0 : overflow_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_count_q <= '0;
      prev_valid_q <= 1'b0;
      epoch_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      prev_count_q <= prev_count_d;
      prev_valid_q <= prev_valid_d;
      epoch_q      <= epoch_d;
      overflow_q   <= overflow_d;
    end
  end
  capture_fifo #(.Width(EpochWidth + Size), .Depth(Depth)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (bus.capture),
    .pop   (bus.out_ready),
    .wdata ({epoch_d, bus.count}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  assign bus.out_valid = !fifo_empty;
  assign bus.out_count = head[Size-1:0];
  assign bus.out_epoch = head[EpochWidth+Size-1:Size];
  assign bus.full      = fifo_full;
  assign bus.empty     = fifo_empty;
  assign bus.overflow  = overflow_q;
  assign bus.epoch     = epoch_q;
endmodule
